// File: rtl/countdown_timer_if.sv
`default_nettype none
// ============================================================================
// countdown_timer_if : control/status bundle for countdown_timer
// Rev 1.0
// ============================================================================
interface countdown_timer_if #(
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = 4
);
    logic                 start;
    logic                 stop;
    logic                 enable;
    logic                 auto_reload;
    logic [WIDTH-1:0]     load_value;
    logic [WIDTH-1:0]     count_out;
    logic                 busy;
    logic                 done;
    logic                 expired;
    logic [EXP_WIDTH-1:0] expiry_count;

    modport master (
        output start, stop, enable, auto_reload, load_value,
        input  count_out, busy, done, expired, expiry_count
    );

    modport slave (
        input  start, stop, enable, auto_reload, load_value,
        output count_out, busy, done, expired, expiry_count
    );
endinterface
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// countdown_timer : loadable down-counter, one-shot/auto-reload, expiry count
// Rev 1.0
// ============================================================================
module countdown_timer #(
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = 4
) (
    input  wire logic           clock,
    input  wire logic           reset,
    countdown_timer_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [WIDTH-1:0]     count_reg, count_next;
    logic [WIDTH-1:0]     reload_reg, reload_next;
    logic [EXP_WIDTH-1:0] exp_reg, exp_next;
    logic                 done_reg, done_next;
    logic                 busy_reg, expired_reg;

    localparam logic [EXP_WIDTH-1:0] EXP_MAX = {EXP_WIDTH{1'b1}};

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            count_reg   <= '0;
            reload_reg  <= '0;
            exp_reg     <= '0;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            expired_reg <= 1'b0;
        end else begin
            state       <= state_next;
            count_reg   <= count_next;
            reload_reg  <= reload_next;
            exp_reg     <= exp_next;
            done_reg    <= done_next;
            busy_reg    <= (state_next == ST_RUN);
            expired_reg <= (state_next == ST_DONE);
        end
    end

    always_comb begin
        state_next  = state;
        count_next  = count_reg;
        reload_next = reload_reg;
        exp_next    = exp_reg;
        done_next   = 1'b0;

        if (bus.stop) begin
            state_next = ST_IDLE;
        end else if (bus.start) begin
            // A restart discards any terminal event of the run it replaces
            reload_next = bus.load_value;
            if (bus.load_value != '0) begin
                count_next = bus.load_value;
                state_next = ST_RUN;
                exp_next   = '0;
            end else begin
                count_next = '0;
                state_next = ST_DONE;
                done_next  = 1'b1;
                exp_next   = EXP_WIDTH'(1);
            end
        end else begin
            case (state)
                ST_IDLE: state_next = ST_IDLE;
                ST_RUN: begin
                    if (bus.enable) begin
                        if (count_reg == WIDTH'(1)) begin
                            done_next = 1'b1;
                            if (exp_reg != EXP_MAX)
                                exp_next = exp_reg + EXP_WIDTH'(1);
                            if (bus.auto_reload) begin
                                count_next = reload_reg;
                            end else begin
                                count_next = '0;
                                state_next = ST_DONE;
                            end
                        end else if (count_reg > WIDTH'(1)) begin
                            count_next = count_reg - WIDTH'(1);
                        end
                    end
                end
                ST_DONE: count_next = '0;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign bus.count_out    = count_reg;
    assign bus.busy         = busy_reg;
    assign bus.done         = done_reg;
    assign bus.expired      = expired_reg;
    assign bus.expiry_count = exp_reg;
endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// tb_countdown_timer : directed + randomized checks against a timer model
// Rev 1.0
// ============================================================================
module tb_countdown_timer;
    localparam int WIDTH     = 8;
    localparam int EXP_WIDTH = 4;
    localparam int EXP_SAT   = (1 << EXP_WIDTH) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    countdown_timer_if #(.WIDTH(WIDTH), .EXP_WIDTH(EXP_WIDTH)) bus ();

    countdown_timer #(.WIDTH(WIDTH), .EXP_WIDTH(EXP_WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: mode 0 = idle, 1 = counting, 2 = expired
    int m_mode = 0, m_count = 0, m_reload = 0, m_exp = 0, m_done = 0;
    bit checking = 0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clock) begin
        m_done = 0;
        if (reset) begin
            m_mode = 0; m_count = 0; m_reload = 0; m_exp = 0;
            checking = 1;
        end else if (bus.stop) begin
            m_mode = 0;
        end else if (bus.start) begin
            m_reload = int'(bus.load_value);
            if (m_reload != 0) begin
                m_mode = 1; m_count = m_reload; m_exp = 0;
            end else begin
                m_mode = 2; m_count = 0; m_done = 1; m_exp = 1;
            end
        end else if (m_mode == 1 && bus.enable) begin
            if (m_count == 1) begin
                m_done = 1;
                m_exp  = (m_exp < EXP_SAT) ? m_exp + 1 : EXP_SAT;
                if (bus.auto_reload) m_count = m_reload;
                else begin m_count = 0; m_mode = 2; end
            end else begin
                m_count = m_count - 1;
            end
        end
        #1;
        if (checking) begin
            check("count_out",    int'(bus.count_out),    m_count);
            check("busy",         int'(bus.busy),         int'(m_mode == 1));
            check("done",         int'(bus.done),         m_done);
            check("expired",      int'(bus.expired),      int'(m_mode == 2));
            check("expiry_count", int'(bus.expiry_count), m_exp);
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic drive(bit st, bit sp, bit en, bit ar, int lv);
        bus.start       = st;
        bus.stop        = sp;
        bus.enable      = en;
        bus.auto_reload = ar;
        bus.load_value  = WIDTH'(lv);
    endtask

    int done_seen;

    initial begin
        drive(0, 0, 0, 0, 0);
        reset = 1;
        tick(); tick();
        reset = 0;
        check("lit_reset_count", int'(bus.count_out), 0);
        check("lit_reset_busy",  int'(bus.busy), 0);

        // One-shot from 5
        drive(1, 0, 1, 0, 5); tick();
        bus.start = 0;
        check("lit_os_load", int'(bus.count_out), 5);
        for (int i = 4; i >= 0; i--) begin
            tick();
            check("lit_os_count", int'(bus.count_out), i);
        end
        check("lit_os_done",    int'(bus.done), 1);
        check("lit_os_expired", int'(bus.expired), 1);
        check("lit_os_busy",    int'(bus.busy), 0);
        check("lit_os_exp",     int'(bus.expiry_count), 1);
        tick();
        check("lit_os_done_clr", int'(bus.done), 0);
        for (int i = 0; i < 10; i++) tick();
        check("lit_os_hold0", int'(bus.count_out), 0);

        // Enable gap at count 2: done at start edge + 5
        drive(1, 0, 1, 0, 3); tick();
        bus.start = 0;
        tick();
        check("lit_gap_2", int'(bus.count_out), 2);
        bus.enable = 0; tick(); tick();
        check("lit_gap_hold", int'(bus.count_out), 2);
        bus.enable = 1; tick();
        check("lit_gap_done_early", int'(bus.done), 0);
        tick();
        check("lit_gap_done", int'(bus.done), 1);

        // Auto-reload period 4, load_value change ignored mid-run
        drive(1, 0, 1, 1, 4); tick();
        bus.start = 0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            done_seen += int'(bus.done);
        end
        check("lit_ar_dones", done_seen, 3);
        check("lit_ar_exp",   int'(bus.expiry_count), 3);
        check("lit_ar_count", int'(bus.count_out), 4);
        bus.load_value = 8'd9;
        for (int i = 0; i < 4; i++) tick();
        check("lit_ar_period", int'(bus.count_out), 4);
        for (int i = 0; i < 80; i++) tick();
        check("lit_ar_sat", int'(bus.expiry_count), 15);
        tick();
        bus.stop = 1; tick();
        bus.stop = 0;
        check("lit_stop_busy",  int'(bus.busy), 0);
        check("lit_stop_count", int'(bus.count_out), 3);

        // Zero load expires immediately
        drive(1, 0, 1, 0, 0); tick();
        bus.start = 0;
        check("lit_z_done", int'(bus.done), 1);
        check("lit_z_exp",  int'(bus.expiry_count), 1);
        tick();
        check("lit_z_done_clr", int'(bus.done), 0);

        // start+stop together at count 6
        drive(1, 0, 1, 0, 10); tick();
        bus.start = 0;
        for (int i = 0; i < 4; i++) tick();
        drive(1, 1, 1, 0, 3); tick();
        drive(0, 0, 1, 0, 3);
        check("lit_ss_count", int'(bus.count_out), 6);
        check("lit_ss_busy",  int'(bus.busy), 0);

        // Restart at terminal count suppresses done
        drive(1, 0, 1, 0, 2); tick();
        bus.start = 0; tick();
        drive(1, 0, 1, 0, 9); tick();
        bus.start = 0;
        check("lit_rs_count", int'(bus.count_out), 9);
        check("lit_rs_done",  int'(bus.done), 0);
        check("lit_rs_exp",   int'(bus.expiry_count), 0);

        // Reset mid-run with start asserted
        drive(1, 0, 1, 0, 9); tick();
        bus.start = 0; tick(); tick();
        bus.start = 1; reset = 1; tick();
        reset = 0;
        check("lit_rst_count", int'(bus.count_out), 0);
        check("lit_rst_busy",  int'(bus.busy), 0);
        drive(1, 0, 1, 0, 5); tick();
        bus.start = 0;
        check("lit_rst_restart", int'(bus.count_out), 5);
        tick();
        check("lit_rst_dec", int'(bus.count_out), 4);

        // Randomized traffic checked each cycle by the model
        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(0, 199) == 0);
            bus.stop        = ($urandom_range(0, 39) == 0);
            bus.start       = ($urandom_range(0, 14) == 0);
            bus.enable      = ($urandom_range(0, 3) != 0);
            bus.auto_reload = ($urandom_range(0, 1) == 1);
            bus.load_value  = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom)
                                                          : WIDTH'($urandom_range(0, 6));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
